dsram_axil: RTL and testbench



---
 rtl/dsram_axil.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dsram_axil.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_axil.sv
`default_nettype none
// ============================================================================
// Module   : dsram_axil
// Purpose  : AXI-lite data SRAM responder. Word-addressed array serving one
//            read or one write at a time, with a fixed, parameterised response
//            latency on each channel and DECERR for out-of-window addresses.
// Revision : 1.0 - initial release
// ============================================================================
module dsram_axil #(
  parameter int          DEPTH  = 1024,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          RD_LAT = 1,
  parameter int          WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // read address / data
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  // write address / data / response
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IW      = $clog2(DEPTH);
  localparam logic [3:0]  RD_CNT0 = 4'(RD_LAT - 1);
  localparam logic [3:0]  WR_CNT0 = 4'(WR_LAT - 1);
  // One past the last byte of the window, kept 33 bits wide so a window that
  // ends at the top of the address space does not wrap.
  localparam logic [32:0] LIMIT   = {1'b0, BASE} + (33'(DEPTH) << 2);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  DECERR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] araddr_q, araddr_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [31:0] mem_q [DEPTH];

  logic        is_idle;
  logic        ar_hs, aw_hs, w_hs;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        rd_load, wr_commit, mem_we;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE) >> 2);
  endfunction

  assign is_idle = (state_q == IDLE);

  // Reads win only while no write half is parked; a parked half locks reads
  // out until its write has responded.
  assign arready = !rst && is_idle && !aw_got_q && !w_got_q;
  assign awready = !rst && is_idle && !aw_got_q && !(arvalid && !w_got_q);
  assign wready  = !rst && is_idle && !w_got_q  && !(arvalid && !aw_got_q);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;

  // With RD_LAT=1 the data is fetched on the AR handshake edge itself, so the
  // live bus address is used; afterwards the captured copy is.
  assign rd_addr = is_idle ? araddr : araddr_q;

  // A half that arrives on the completing edge is taken straight off the bus.
  assign wr_addr = aw_got_q ? awaddr_q : awaddr;
  assign wr_data = w_got_q  ? wdata_q  : wdata;
  assign wr_strb = w_got_q  ? wstrb_q  : wstrb;

  // A reset on the commit edge discards the write.
  assign mem_we = wr_commit && !rst && in_range(wr_addr);

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;

  // Next-state logic: transaction sequencing, write-half capture, responses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rd_load   = 1'b0;
    wr_commit = 1'b0;

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (ar_hs) begin
          araddr_d = araddr;
          cnt_d    = RD_CNT0;
          if (RD_LAT == 1) begin
            state_d = RD_RESP;
            rd_load = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end else if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          cnt_d = WR_CNT0;
          if (WR_LAT == 1) begin
            state_d   = WR_RESP;
            wr_commit = 1'b1;
          end else begin
            state_d = WR_WAIT;
          end
        end
      end

      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RD_RESP;
          rd_load = 1'b1;
        end
      end

      RD_RESP: begin
        if (rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end

      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = WR_RESP;
          wr_commit = 1'b1;
        end
      end

      WR_RESP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    if (rd_load) begin
      rvalid_d = 1'b1;
      if (in_range(rd_addr)) begin
        rdata_d = mem_q[word_idx(rd_addr)];
        rresp_d = OKAY;
      end else begin
        rdata_d = 32'd0;
        rresp_d = DECERR;
      end
    end

    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = in_range(wr_addr) ? OKAY : DECERR;
    end
  end

  // Control and response registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      araddr_q <= 32'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= OKAY;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      araddr_q <= araddr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  // Storage array: not reset, byte-lane write on the edge that raises bvalid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem_q[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsram_axil.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsram_axil
// Purpose  : Scoreboard bench for dsram_axil. Two instances (latency 1/1 and
//            4/3) are exercised in turn against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsram_axil;

  localparam int          TDEPTH = 64;
  localparam logic [31:0] TBASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr [2];
  logic        arvalid[2], arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2], rready [2];
  logic [31:0] awaddr [2];
  logic        awvalid[2], awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2], wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2], bready [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dsram_axil #(
      .DEPTH (TDEPTH),
      .BASE  (TBASE),
      .RD_LAT(k == 0 ? 1 : 4),
      .WR_LAT(k == 0 ? 1 : 3)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .araddr (araddr[k]),
      .arvalid(arvalid[k]),
      .arready(arready[k]),
      .rdata  (rdata[k]),
      .rresp  (rresp[k]),
      .rvalid (rvalid[k]),
      .rready (rready[k]),
      .awaddr (awaddr[k]),
      .awvalid(awvalid[k]),
      .awready(awready[k]),
      .wdata  (wdata[k]),
      .wstrb  (wstrb[k]),
      .wvalid (wvalid[k]),
      .wready (wready[k]),
      .bresp  (bresp[k]),
      .bvalid (bvalid[k]),
      .bready (bready[k])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        kind;   // 0 read, 1 write
    logic [1:0]  resp;
    logic [31:0] data;
    logic [31:0] cyc;    // cycle in which valid must first appear
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [2][TDEPTH];
  int          sel = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  bit          r_act = 0, b_act = 0, r_after = 0, b_after = 0;
  logic [33:0] r_hold;
  logic [1:0]  b_hold;
  int          r_wait = 0, r_need = 0, r_force = -1;
  int          b_wait = 0, b_need = 0;

  function automatic int rdl(int k); return (k == 0) ? 1 : 4; endfunction
  function automatic int wrl(int k); return (k == 0) ? 1 : 3; endfunction

  function automatic bit m_inr(logic [31:0] a);
    longint x = {32'd0, a};
    longint b = {32'd0, TBASE};
    return (x >= b) && (x < b + 4 * TDEPTH);
  endfunction

  function automatic int m_idx(logic [31:0] a);
    return int'((a - TBASE) / 4);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic push_read(input logic [31:0] a);
    exp_t e;
    e.kind = 1'b0;
    e.cyc  = 32'(cyc + rdl(sel));
    if (m_inr(a)) begin
      e.resp = 2'b00;
      e.data = mdl[sel][m_idx(a)];
    end else begin
      e.resp = 2'b11;
      e.data = 32'd0;
    end
    sbq.push_back(e);
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.kind = 1'b1;
    e.data = 32'd0;
    e.cyc  = 32'(cyc + wrl(sel));
    e.resp = m_inr(a) ? 2'b00 : 2'b11;
    if (m_inr(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[sel][m_idx(a)][8*b +: 8] = d[8*b +: 8];
    sbq.push_back(e);
  endtask

  // One transaction: optional read and/or write, with per-half start delays.
  task automatic txn(input bit do_rd, input logic [31:0] ra, input bit do_wr,
                     input int aw_dly, input int w_dly, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [3:0] ws);
    bit rd_done, aw_done, w_done, pushed;
    int n;
    rd_done = !do_rd; aw_done = !do_wr; w_done = !do_wr; pushed = 0; n = 0;
    while (!(rd_done && aw_done && w_done)) begin
      @(negedge clk);
      araddr[sel]  = ra;  arvalid[sel] = !rd_done;
      awaddr[sel]  = wa;  awvalid[sel] = !aw_done && (n >= aw_dly);
      wdata[sel]   = wd;  wstrb[sel]   = ws;
      wvalid[sel]  = !w_done && (n >= w_dly);
      #1;
      if (do_rd && do_wr && !rd_done && !aw_done && !w_done)
        chk("wr_blocked_by_ar", {awready[sel], wready[sel]}, 2'b00);
      if (arvalid[sel] && arready[sel]) begin rd_done = 1; push_read(ra); end
      if (awvalid[sel] && awready[sel]) aw_done = 1;
      if (wvalid[sel] && wready[sel]) w_done = 1;
      if (do_wr && aw_done && w_done && !pushed) begin pushed = 1; push_write(wa, wd, ws); end
      n++;
      if (n > 300) begin fail("txn_handshake_timeout"); break; end
    end
    @(negedge clk);
    arvalid[sel] = 0; awvalid[sel] = 0; wvalid[sel] = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || r_act || b_act) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    int c = $urandom_range(0, 9);
    if (c < 8) return TBASE + 32'($urandom_range(0, 4 * TDEPTH - 1));
    else if (c == 8) return TBASE + 32'(4 * TDEPTH) + 32'($urandom_range(0, 255));
    else return TBASE - 32'($urandom_range(1, 256));
  endfunction

  // Master-side backpressure on R and B for the selected instance.
  always @(negedge clk) begin
    rready[0] = 0; rready[1] = 0; bready[0] = 0; bready[1] = 0;
    if (!rst && rvalid[sel]) begin
      rready[sel] = (r_wait >= r_need);
      r_wait++;
    end else begin
      r_wait = 0;
      r_need = (r_force >= 0) ? r_force : int'($urandom_range(0, 2));
    end
    if (!rst && bvalid[sel]) begin
      bready[sel] = (b_wait >= b_need);
      b_wait++;
    end else begin
      b_wait = 0;
      b_need = $urandom_range(0, 2);
    end
  end

  // Response monitor: pops the scoreboard on the first cycle of each valid.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      r_act = 0; b_act = 0; r_after = 0; b_after = 0;
    end else begin
      if (rvalid[sel] || bvalid[sel])
        chk("rb_exclusive", {63'd0, rvalid[sel] && bvalid[sel]}, 64'd0);
      if (r_after) begin
        chk("arready_after_r", {63'd0, arready[sel]}, 64'd1);
        r_after = 0;
      end
      if (b_after) begin
        chk("arready_after_b", {63'd0, arready[sel]}, 64'd1);
        if (!arvalid[sel]) chk("wready_after_b", {awready[sel], wready[sel]}, 2'b11);
        b_after = 0;
      end
      if (rvalid[sel]) begin
        if (!r_act) begin
          if (sbq.size() == 0) fail("r_unexpected");
          else begin
            e = sbq.pop_front();
            chk("r_kind", e.kind, 1'b0);
            chk("r_latency", 32'(cyc), e.cyc);
            chk("r_data", rdata[sel], e.data);
            chk("r_resp", rresp[sel], e.resp);
          end
          r_hold = {rdata[sel], rresp[sel]};
          r_act = 1;
        end else begin
          chk("r_stable", {rdata[sel], rresp[sel]}, r_hold);
        end
        if (rready[sel]) begin r_act = 0; r_after = 1; end
      end else if (r_act) begin
        fail("rvalid_dropped");
        r_act = 0;
      end
      if (bvalid[sel]) begin
        if (!b_act) begin
          if (sbq.size() == 0) fail("b_unexpected");
          else begin
            e = sbq.pop_front();
            chk("b_kind", e.kind, 1'b1);
            chk("b_latency", 32'(cyc), e.cyc);
            chk("b_resp", bresp[sel], e.resp);
          end
          b_hold = bresp[sel];
          b_act = 1;
        end else begin
          chk("b_stable", bresp[sel], b_hold);
        end
        if (bready[sel]) begin b_act = 0; b_after = 1; end
      end else if (b_act) begin
        fail("bvalid_dropped");
        b_act = 0;
      end
    end
  end

  int          kind;
  logic [31:0] a1, a2;

  initial begin
    for (int k = 0; k < 2; k++) begin
      araddr[k] = 0; arvalid[k] = 0; awaddr[k] = 0; awvalid[k] = 0;
      wdata[k] = 0; wstrb[k] = 0; wvalid[k] = 0;
    end
    rst = 1;
    repeat (3) begin
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk("rst_outputs", {rvalid[k], bvalid[k], rdata[k], rresp[k], bresp[k]}, 64'd0);
        chk("rst_readies", {arready[k], awready[k], wready[k]}, 3'b000);
      end
    end
    @(negedge clk);
    rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_outputs", {rvalid[k], bvalid[k], rdata[k], rresp[k], bresp[k]}, 64'd0);
      chk("post_rst_readies", {arready[k], awready[k], wready[k]}, 3'b111);
    end

    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < TDEPTH; i++)
        txn(0, 0, 1, 0, 0, TBASE + 32'(4 * i), $urandom(), 4'hF);
      drain();

      // full-word write then readback
      txn(0, 0, 1, 0, 0, TBASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
      txn(1, TBASE + 32'h10, 0, 0, 0, 0, 0, 0);
      // W three cycles ahead of AW, single byte lane
      txn(0, 0, 1, 3, 0, TBASE + 32'h10, 32'h00AB_0000, 4'b0100);
      txn(1, TBASE + 32'h10, 0, 0, 0, 0, 0, 0);
      // read and write offered together: read goes first, sees old data
      txn(1, TBASE + 32'h10, 1, 0, 0, TBASE + 32'h10, 32'h1234_5678, 4'hF);
      txn(1, TBASE + 32'h10, 0, 0, 0, 0, 0, 0);
      drain();
      // held-off rready
      r_force = 5;
      txn(1, TBASE + 32'h14, 0, 0, 0, 0, 0, 0);
      drain();
      r_force = -1;
      // window edges and empty strobe
      txn(1, TBASE + 32'(4 * TDEPTH), 0, 0, 0, 0, 0, 0);
      txn(0, 0, 1, 0, 0, TBASE - 32'd4, 32'hCAFE_F00D, 4'hF);
      txn(1, TBASE + 32'(4 * TDEPTH - 4), 0, 0, 0, 0, 0, 0);
      txn(0, 0, 1, 0, 0, TBASE + 32'h18, 32'h5555_5555, 4'h0);
      txn(1, TBASE + 32'h18, 0, 0, 0, 0, 0, 0);
      drain();

      if (s == 1) begin
        // reset while the write is still counting down
        @(negedge clk);
        awaddr[sel] = TBASE + 32'h20; wdata[sel] = 32'hA5A5_A5A5; wstrb[sel] = 4'hF;
        awvalid[sel] = 1; wvalid[sel] = 1;
        #1;
        chk("rstw_accept", {awready[sel], wready[sel]}, 2'b11);
        @(negedge clk);
        awvalid[sel] = 0; wvalid[sel] = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rstw_readies", {arready[sel], awready[sel], wready[sel]}, 3'b111);
        chk("rstw_bvalid", {63'd0, bvalid[sel]}, 64'd0);
        repeat (6) @(negedge clk);
        txn(1, TBASE + 32'h20, 0, 0, 0, 0, 0, 0);
        drain();
      end

      for (int i = 0; i < 150; i++) begin
        kind = $urandom_range(0, 2);
        a1 = rnd_addr();
        a2 = rnd_addr();
        txn(kind != 1, a1, kind != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            a2, $urandom(), 4'($urandom()));
      end
      drain();

      for (int i = 0; i < TDEPTH; i++)
        txn(1, TBASE + 32'(4 * i), 0, 0, 0, 0, 0, 0);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
